// File: rtl/fruit_sprite_scheduler_if.sv
// fruit_sprite_scheduler_if: fruit table write handshake between the game logic and the sprite scheduler
interface fruit_sprite_scheduler_if #(
  parameter int NUM_FRUITS = 4
) ();
  localparam int IW = $clog2(NUM_FRUITS);
  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_idx;
  logic [9:0]    wr_x;
  logic [9:0]    wr_y;
  logic [9:0]    wr_size;
  logic          wr_en;
  modport master (output wr_valid, wr_idx, wr_x, wr_y, wr_size, wr_en, input wr_ready);
  modport slave  (input wr_valid, wr_idx, wr_x, wr_y, wr_size, wr_en, output wr_ready);
endinterface

// File: rtl/fruit_sprite_scheduler.sv
// fruit_sprite_scheduler: per-scanline sprite list builder and pixel selector; FRUIT_SCHED_ROTATE_EN rotates the scan start index each frame
module fruit_sprite_scheduler #(
  parameter int NUM_FRUITS = 4,
  parameter int LINE_SLOTS = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  localparam int IW = $clog2(NUM_FRUITS),
  localparam int SW = $clog2(LINE_SLOTS + 1)
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  fruit_sprite_scheduler_if.slave  wr,
  output logic [9:0]               FruitX,
  output logic [9:0]               FruitY,
  output logic [9:0]               Fruit_size,
  output logic [IW-1:0]            fruit_id,
  output logic                     fruit_hit,
  output logic                     line_overflow
);
  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] size;
  } entry_t;
  typedef struct packed {
    logic          v;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [9:0]    size;
    logic [IW-1:0] id;
  } slot_t;
  typedef enum logic {IDLE, SCAN} state_t;

  entry_t        sh [NUM_FRUITS];
  entry_t        cm [NUM_FRUITS];
  slot_t         slot [LINE_SLOTS];
  slot_t         sel;
  entry_t        cur;
  state_t        state, state_nx;
  logic [IW-1:0] idx, cnt, start;
  logic [SW-1:0] nslot;
  logic [9:0]    target;
  logic          commit, wr_fire, trigger, vhit, sel_hit, active;

  assign commit      = DrawX == 10'd0 && DrawY == 10'(V_ACTIVE);
  assign wr.wr_ready = !commit;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign target      = DrawY == 10'(V_TOTAL - 1) ? 10'd0 : DrawY + 10'd1;
  assign cur         = cm[idx];
  assign vhit        = cur.en && (target - cur.y) < cur.size;
  assign active      = DrawX < 10'(H_ACTIVE) && DrawY < 10'(V_ACTIVE);

  // game writes land in the shadow table; the whole table is committed at start of vertical blank
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NUM_FRUITS; k++) begin
        sh[k] <= '0;
        cm[k] <= '0;
      end
    end else begin
      if (wr_fire) sh[wr.wr_idx] <= '{wr.wr_en, wr.wr_x, wr.wr_y, wr.wr_size};
      if (commit) cm <= sh;
    end
  end

`ifdef FRUIT_SCHED_ROTATE_EN
  // scan start advances every frame so overflowing fruits take turns being dropped
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) start <= '0;
    else if (commit) start <= start == IW'(NUM_FRUITS - 1) ? '0 : start + 1'b1;
  end
`else
  assign start = '0;
`endif

  // scan state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  end

  // scan starts when horizontal blank begins and lasts one cycle per table entry
  always_comb begin
    trigger  = state == IDLE && DrawX == 10'(H_ACTIVE);
    state_nx = trigger ? SCAN : (state == SCAN && cnt == IW'(NUM_FRUITS - 1)) ? IDLE : state;
  end

  // line list fill: hits take free slots in scan order, excess hits raise the sticky overflow
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx           <= '0;
      cnt           <= '0;
      nslot         <= '0;
      line_overflow <= 1'b0;
      for (int s = 0; s < LINE_SLOTS; s++) slot[s] <= '0;
    end else begin
      if (trigger) begin
        idx   <= start;
        cnt   <= '0;
        nslot <= '0;
        for (int s = 0; s < LINE_SLOTS; s++) slot[s].v <= 1'b0;
      end else if (state == SCAN) begin
        idx <= idx == IW'(NUM_FRUITS - 1) ? '0 : idx + 1'b1;
        cnt <= cnt + 1'b1;
        if (vhit && nslot == SW'(LINE_SLOTS)) line_overflow <= 1'b1;
        else if (vhit) begin
          nslot <= nslot + 1'b1;
          for (int s = 0; s < LINE_SLOTS; s++)
            if (nslot == SW'(s)) slot[s] <= '{1'b1, cur.x, cur.y, cur.size, idx};
        end
      end
      if (commit) line_overflow <= 1'b0;
    end
  end

  // lowest-numbered slot covering DrawX wins
  always_comb begin
    sel_hit = 1'b0;
    sel     = '0;
    for (int s = LINE_SLOTS - 1; s >= 0; s--)
      if (slot[s].v && (DrawX - slot[s].x) < slot[s].size) begin
        sel_hit = 1'b1;
        sel     = slot[s];
      end
  end

  // registered outputs; geometry holds its last value when nothing is drawn
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      FruitX     <= '0;
      FruitY     <= '0;
      Fruit_size <= '0;
      fruit_id   <= '0;
      fruit_hit  <= 1'b0;
    end else begin
      fruit_hit <= active && sel_hit;
      if (active && sel_hit) begin
        FruitX     <= sel.x;
        FruitY     <= sel.y;
        Fruit_size <= sel.size;
        fruit_id   <= sel.id;
      end
    end
  end
endmodule

// File: doc/fruit_sprite_scheduler.md
# fruit_sprite_scheduler

Per-scanline sprite scheduler that shares the single fruit-drawing path of the colour mapper among `NUM_FRUITS` game objects. It sits between the game logic and the colour mapper, and takes its timing from the VGA controller. During each horizontal blank it scans the committed fruit table and builds a line list of up to `LINE_SLOTS` fruits that overlap the next scanline. During active video it outputs, every pixel, the position and size of the highest-priority fruit covering `DrawX`.

## Interface
- `NUM_FRUITS`, default 4: number of fruit table entries (2..8).
- `LINE_SLOTS`, default 2: maximum number of fruits drawn on one scanline.
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines.
- `V_TOTAL`, default 525: total lines per frame.
- `Clk` input 1: pixel clock; one pixel per cycle. The block has one clock; reset is asynchronous and active-low.
- `Reset_n` input 1: asynchronous, active-low reset.
- `DrawX`, `DrawY` input 10: current pixel coordinates from the VGA controller.
- `wr_valid` input 1: request to write one fruit table entry.
- `wr_ready` output 1: write accepted when `wr_valid && wr_ready`.
- `wr_idx` input clog2(`NUM_FRUITS`): index of the table entry to write.
- `wr_x`, `wr_y`, `wr_size` input 10 each: top-left position and side length of the fruit.
- `wr_en` input 1: entry enable; 0 removes the fruit.
- `FruitX`, `FruitY`, `Fruit_size` output 10 each: geometry of the selected fruit, fed to the colour mapper.
- `fruit_id` output clog2(`NUM_FRUITS`): index of the selected fruit.
- `fruit_hit` output 1: the current pixel lies inside the selected fruit.
- `line_overflow` output 1: sticky flag; some line this frame had more than `LINE_SLOTS` hits.

## Operation
- **Fruit tables:**
  - There are two tables, shadow and committed.
  - Writes from the game logic go to the shadow table only.
- **Commit:**
  - Fires on the cycle where `DrawX==0 && DrawY==V_ACTIVE` (start of vertical blank).
  - Copies the whole shadow table into the committed table.
  - Clears `line_overflow`.
  - `wr_ready` is 0 on the commit cycle only and 1 on every other cycle.
  - A write presented on the commit cycle is not accepted; the game logic holds `wr_valid` until accepted.
- **Scan FSM states:**
  - IDLE: on `DrawX==H_ACTIVE` → SCAN, with `i` set to the start index and the slot count cleared.
  - SCAN: evaluates one committed entry per cycle. After `NUM_FRUITS` entries → IDLE.
- **Scan target line:**
  - T = 0 if `DrawY==V_TOTAL-1`, otherwise `DrawY+1`.
  - Lines with T ≥ `V_ACTIVE` are still scanned; they produce no visible effect.
- **Vertical hit test:**
  - Hit when the entry is enabled and `(T - y) < size`, using 10-bit unsigned wrap-around subtraction.
  - The wrap makes T < y fail the test.
- **Slot fill:**
  - Each hit fills the next free slot, in scan order, with {x, y, size, idx}.
  - A hit arriving with all slots full is dropped and sets `line_overflow`.
  - Unfilled slots are marked invalid.
- **Pixel select:**
  - For each valid slot, test `(DrawX - x) < size` (10-bit wrap).
  - The lowest-numbered hitting slot wins. Its fields drive the outputs and `fruit_hit` = 1.
  - With no hit, or with `DrawX ≥ H_ACTIVE` or `DrawY ≥ V_ACTIVE`: `fruit_hit`=0 and the geometry outputs hold their previous values.
- **Reset:**
  - Clears both tables (all entries disabled), all slots, the FSM (→ IDLE) and all outputs.
  - A reset asserted mid-scan abandons the scan; the next line's scan starts cleanly.

## Timing
- **Output reset values:** `FruitX`, `FruitY`, `Fruit_size`, `fruit_id`, `fruit_hit`, `line_overflow` = 0; `wr_ready` = 1.
- **Select-path latency:** 1 cycle. Outputs registered on cycle n+1 describe the `DrawX`/`DrawY` presented on cycle n.
- **Scan duration:** exactly `NUM_FRUITS` cycles from the cycle after the trigger, so it completes inside horizontal blank.
- **Slot update point:** slots are updated during SCAN. The display path ignores slots while `DrawX ≥ H_ACTIVE`, so no separate double buffer is needed.
- **Write latency:** an accepted write lands in the shadow table on the next edge.
  - It becomes visible at the next commit.
  - A write accepted on the cycle before commit is included in that commit.
- **Same-index writes:** two writes to the same index before a commit; the last one wins.

## Configuration
- **Macro:** `FRUIT_SCHED_ROTATE_EN`.
- **Defined:** the scan start index increments by 1, modulo `NUM_FRUITS`, at each commit. Overflowing fruits then take turns being dropped across frames. Reset sets the start index to 0.
- **Not defined:** the scan always starts at index 0. Lower indices have fixed priority, both for slot fill and for the pixel select.

## Test plan
- **Reset:** assert `Reset_n`=0 mid-scan → all outputs 0 and `wr_ready`=1 immediately; after release, no `fruit_hit` anywhere in the frame.
- **Single fruit:** write idx0 x=100 y=50 size=20, wait for commit → on lines 50..69 and pixels 100..119, `fruit_hit`=1 one cycle later with `FruitX`=100 and `fruit_id`=0. Pixel 120 and line 70 → `fruit_hit`=0.
- **Overlap priority:** idx1 and idx2 both at (200,200) size 10 → `fruit_id`=1 on the overlap.
- **Overflow:** three fruits on line 300 with `LINE_SLOTS`=2 → idx2 never hits and `line_overflow`=1 until the next commit.
  - With `FRUIT_SCHED_ROTATE_EN` defined, the dropped index changes every frame.
- **Commit handshake:** hold `wr_valid` across the commit cycle → `wr_ready`=0 for exactly that cycle, the write is accepted the next cycle, and it is displayed one frame later.
- **Wrap boundaries:** a fruit at y=0 is scanned at `DrawY`=524 and drawn on line 0. A fruit at x=630 size 20 → hits only on pixels 630..639, with no hit during blank.
